cpu_sequencer: RTL and testbench

//  Multi-cycle control FSM for the mos6502 datapath. It sequences instruction fetch,

---
 rtl/cpu_sequencer.sv | 166 ++++++++++++++++
 tb/tb_cpu_sequencer.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_sequencer.sv
// Multi-cycle control sequencer for the mos6502 datapath: fetch, decode, absolute operand
// fetch and memory access for LDA #imm, LDA abs, STA abs, JMP abs and NOP.
module cpu_sequencer #(
  parameter int unsigned RESET_CYCLES    = 2,
  parameter bit          HALT_ON_ILLEGAL = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rdy,
  input  logic [7:0]  opcode,
  output logic        il,
  output logic        mw,
  output logic        mm,
  output logic        pc_inc,
  output logic        pc_load,
  output logic        al_lo,
  output logic        al_hi,
  output logic        a_load,
  output logic        a_drive,
  output logic        sync,
  output logic        halt,
  output logic [15:0] instr_cnt
);

  localparam logic IlNoload = 1'b0;
  localparam logic IlLoad   = 1'b1;
  localparam logic MwRead   = 1'b0;
  localparam logic MwWrite  = 1'b1;
  localparam logic MmPcAddr = 1'b0;
  localparam logic MmAAddr  = 1'b1;

  localparam logic [7:0] OpLdaImm = 8'hA9;
  localparam logic [7:0] OpLdaAbs = 8'hAD;
  localparam logic [7:0] OpStaAbs = 8'h8D;
  localparam logic [7:0] OpJmpAbs = 8'h4C;
  localparam logic [7:0] OpNop    = 8'hEA;

  localparam logic [3:0] WaitInit = 4'(RESET_CYCLES - 1);

  typedef enum logic [2:0] {StRst, StFetch, StDec, StAbsh, StMem, StHalt} state_e;

  state_e      state_q, state_d;
  logic [3:0]  wait_q, wait_d;
  logic [15:0] instr_cnt_q;
  logic        done;
  logic        seq_state;
  logic        stall;

  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    done      = 1'b0;
    seq_state = 1'b0;
    il        = IlNoload;
    mw        = MwRead;
    mm        = MmPcAddr;
    pc_inc    = 1'b0;
    pc_load   = 1'b0;
    al_lo     = 1'b0;
    al_hi     = 1'b0;
    a_load    = 1'b0;
    a_drive   = 1'b0;
    sync      = 1'b0;
    halt      = 1'b0;

    case (state_q)
      StRst: begin
        if (wait_q == 4'd0) state_d = StFetch;
        else                wait_d  = wait_q - 4'd1;
      end
      StFetch: begin
        seq_state = 1'b1;
        il        = IlLoad;
        pc_inc    = 1'b1;
        sync      = 1'b1;
        state_d   = StDec;
      end
      StDec: begin
        seq_state = 1'b1;
        case (opcode)
          OpNop: begin
            state_d = StFetch;
            done    = 1'b1;
          end
          OpLdaImm: begin
            a_load  = 1'b1;
            pc_inc  = 1'b1;
            state_d = StFetch;
            done    = 1'b1;
          end
          OpLdaAbs, OpStaAbs, OpJmpAbs: begin
            al_lo   = 1'b1;
            pc_inc  = 1'b1;
            state_d = StAbsh;
          end
          default: begin
            if (HALT_ON_ILLEGAL) begin
              state_d = StHalt;
            end else begin
              state_d = StFetch;
              done    = 1'b1;
            end
          end
        endcase
      end
      StAbsh: begin
        seq_state = 1'b1;
        if (opcode == OpJmpAbs) begin
          pc_load = 1'b1;
          state_d = StFetch;
          done    = 1'b1;
        end else begin
          al_hi   = 1'b1;
          pc_inc  = 1'b1;
          state_d = StMem;
        end
      end
      StMem: begin
        seq_state = 1'b1;
        mm        = MmAAddr;
        if (opcode == OpStaAbs) begin
          mw      = MwWrite;
          a_drive = 1'b1;
        end else begin
          a_load  = 1'b1;
        end
        state_d = StFetch;
        done    = 1'b1;
      end
      StHalt: begin
        halt = 1'b1;
      end
      default: begin
        state_d = StRst;
      end
    endcase

    // A not-ready read cycle repeats unchanged; mm, mw and sync stay visible.
    stall = seq_state && (mw == MwRead) && !rdy;
    if (stall) begin
      il      = IlNoload;
      pc_inc  = 1'b0;
      pc_load = 1'b0;
      al_lo   = 1'b0;
      al_hi   = 1'b0;
      a_load  = 1'b0;
      state_d = state_q;
      done    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StRst;
      wait_q      <= WaitInit;
      instr_cnt_q <= 16'd0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      if (done) instr_cnt_q <= instr_cnt_q + 16'd1;
    end
  end

  assign instr_cnt = instr_cnt_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Scoreboard bench for cpu_sequencer: per-cycle stimulus and expected outputs are queued,
// then replayed against the DUT and compared at the falling edge.
module tb_cpu_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rdy = 1'b1;
  logic [7:0]  opcode = 8'hEA;
  logic        il, mw, mm, pc_inc, pc_load, al_lo, al_hi, a_load, a_drive, sync, halt;
  logic [15:0] instr_cnt;
  logic        n_il, n_mw, n_mm, n_pc_inc, n_pc_load, n_al_lo, n_al_hi, n_a_load, n_a_drive;
  logic        n_sync, n_halt;
  logic [15:0] n_instr_cnt;

  always #5 clk = ~clk;

  cpu_sequencer #(.RESET_CYCLES(2), .HALT_ON_ILLEGAL(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .rdy(rdy), .opcode(opcode), .il(il), .mw(mw), .mm(mm),
    .pc_inc(pc_inc), .pc_load(pc_load), .al_lo(al_lo), .al_hi(al_hi), .a_load(a_load),
    .a_drive(a_drive), .sync(sync), .halt(halt), .instr_cnt(instr_cnt)
  );

  cpu_sequencer #(.RESET_CYCLES(2), .HALT_ON_ILLEGAL(1'b0)) dut_nh (
    .clk(clk), .rst_n(rst_n), .rdy(rdy), .opcode(opcode), .il(n_il), .mw(n_mw), .mm(n_mm),
    .pc_inc(n_pc_inc), .pc_load(n_pc_load), .al_lo(n_al_lo), .al_hi(n_al_hi),
    .a_load(n_a_load), .a_drive(n_a_drive), .sync(n_sync), .halt(n_halt),
    .instr_cnt(n_instr_cnt)
  );

  // {il, mw, mm, pc_inc, pc_load, al_lo, al_hi, a_load, a_drive, sync, halt}
  wire [10:0] outs   = {il, mw, mm, pc_inc, pc_load, al_lo, al_hi, a_load, a_drive, sync, halt};
  wire [10:0] n_outs = {n_il, n_mw, n_mm, n_pc_inc, n_pc_load, n_al_lo, n_al_hi, n_a_load,
                        n_a_drive, n_sync, n_halt};

  localparam logic [10:0] V_IDLE      = 11'b0_0_0_0_0_0_0_0_0_0_0;
  localparam logic [10:0] V_FETCH     = 11'b1_0_0_1_0_0_0_0_0_1_0;
  localparam logic [10:0] V_FETCH_STL = 11'b0_0_0_0_0_0_0_0_0_1_0;
  localparam logic [10:0] V_DEC_IMM   = 11'b0_0_0_1_0_0_0_1_0_0_0;
  localparam logic [10:0] V_DEC_ABS   = 11'b0_0_0_1_0_1_0_0_0_0_0;
  localparam logic [10:0] V_ABSH_JMP  = 11'b0_0_0_0_1_0_0_0_0_0_0;
  localparam logic [10:0] V_ABSH_HI   = 11'b0_0_0_1_0_0_1_0_0_0_0;
  localparam logic [10:0] V_MEM_LDA   = 11'b0_0_1_0_0_0_0_1_0_0_0;
  localparam logic [10:0] V_MEM_STL   = 11'b0_0_1_0_0_0_0_0_0_0_0;
  localparam logic [10:0] V_MEM_STA   = 11'b0_1_1_0_0_0_0_0_1_0_0;
  localparam logic [10:0] V_HALT      = 11'b0_0_0_0_0_0_0_0_0_0_1;

  typedef struct {
    string       name;
    logic        rdy;
    logic [7:0]  opc;
    logic [10:0] outs;
    logic [15:0] cnt;
  } entry_t;

  entry_t      q[$];
  logic [15:0] m_cnt = 16'd0;
  int          n_tests = 0;
  int          n_fail = 0;

  task automatic push(input string name, input logic r, input logic [7:0] opc,
                      input logic [10:0] o, input logic d);
    q.push_back('{name, r, opc, o, m_cnt});
    if (d) m_cnt = m_cnt + 16'd1;
  endtask

  // Nominal (rdy=1) cycle sequence for one supported instruction.
  task automatic push_instr(input logic [7:0] opc);
    push("fetch", 1'b1, opc, V_FETCH, 1'b0);
    case (opc)
      8'hEA: push("dec_nop", 1'b1, opc, V_IDLE, 1'b1);
      8'hA9: push("dec_imm", 1'b1, opc, V_DEC_IMM, 1'b1);
      8'h4C: begin
        push("dec_abs", 1'b1, opc, V_DEC_ABS, 1'b0);
        push("absh_jmp", 1'b1, opc, V_ABSH_JMP, 1'b1);
      end
      default: begin
        push("dec_abs", 1'b1, opc, V_DEC_ABS, 1'b0);
        push("absh_hi", 1'b1, opc, V_ABSH_HI, 1'b0);
        if (opc == 8'h8D) push("mem_sta", 1'b1, opc, V_MEM_STA, 1'b1);
        else              push("mem_lda", 1'b1, opc, V_MEM_LDA, 1'b1);
      end
    endcase
  endtask

  // Entered and left at 1 time unit after a rising edge.
  task automatic run_queue(input string test);
    entry_t e;
    while (q.size() > 0) begin
      e = q.pop_front();
      rdy    = e.rdy;
      opcode = e.opc;
      @(negedge clk);
      n_tests++;
      if (outs !== e.outs) begin
        n_fail++;
        $display("FAIL %s/%s outputs got %b want %b", test, e.name, outs, e.outs);
      end
      n_tests++;
      if (instr_cnt !== e.cnt) begin
        n_fail++;
        $display("FAIL %s/%s instr_cnt got %h want %h", test, e.name, instr_cnt, e.cnt);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    m_cnt = 16'd0;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    n_tests++;
    if (outs !== V_IDLE) begin
      n_fail++;
      $display("FAIL reset outputs got %b want %b", outs, V_IDLE);
    end
    n_tests++;
    if (instr_cnt !== 16'd0) begin
      n_fail++;
      $display("FAIL reset instr_cnt got %h want 0000", instr_cnt);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    push("rst0", 1'b1, 8'hEA, V_IDLE, 1'b0);
    push("rst1", 1'b1, 8'hEA, V_IDLE, 1'b0);
    push_instr(8'hEA);
    run_queue("reset");
  endtask

  task automatic test_stream();
    push_instr(8'hA9);
    push_instr(8'h8D);
    push_instr(8'h4C);
    push_instr(8'hEA);
    run_queue("stream");
  endtask

  task automatic test_stall();
    push("fetch_stl", 1'b0, 8'hAD, V_FETCH_STL, 1'b0);
    push("fetch", 1'b1, 8'hAD, V_FETCH, 1'b0);
    push("dec_abs", 1'b1, 8'hAD, V_DEC_ABS, 1'b0);
    for (int i = 0; i < 3; i++) push("absh_stl", 1'b0, 8'hAD, V_IDLE, 1'b0);
    push("absh_hi", 1'b1, 8'hAD, V_ABSH_HI, 1'b0);
    push("mem_lda", 1'b1, 8'hAD, V_MEM_LDA, 1'b1);
    push("fetch", 1'b1, 8'hA9, V_FETCH, 1'b0);
    push("dec_stl", 1'b0, 8'hA9, V_IDLE, 1'b0);
    push("dec_imm", 1'b1, 8'hA9, V_DEC_IMM, 1'b1);
    push("fetch", 1'b1, 8'hAD, V_FETCH, 1'b0);
    push("dec_abs", 1'b1, 8'hAD, V_DEC_ABS, 1'b0);
    push("absh_hi", 1'b1, 8'hAD, V_ABSH_HI, 1'b0);
    push("mem_stl", 1'b0, 8'hAD, V_MEM_STL, 1'b0);
    push("mem_lda", 1'b1, 8'hAD, V_MEM_LDA, 1'b1);
    run_queue("stall");
  endtask

  task automatic test_write_no_rdy();
    push("fetch", 1'b1, 8'h8D, V_FETCH, 1'b0);
    push("dec_abs", 1'b1, 8'h8D, V_DEC_ABS, 1'b0);
    push("absh_hi", 1'b1, 8'h8D, V_ABSH_HI, 1'b0);
    push("mem_sta", 1'b0, 8'h8D, V_MEM_STA, 1'b1);
    push_instr(8'hEA);
    run_queue("write_no_rdy");
  endtask

  task automatic test_illegal();
    push("fetch", 1'b1, 8'h02, V_FETCH, 1'b0);
    push("dec_ill", 1'b1, 8'h02, V_IDLE, 1'b0);
    run_queue("illegal");
    @(negedge clk);
    n_tests++;
    if (n_outs !== V_FETCH) begin
      n_fail++;
      $display("FAIL illegal_nop outputs got %b want %b", n_outs, V_FETCH);
    end
    n_tests++;
    if (n_instr_cnt !== m_cnt + 16'd1) begin
      n_fail++;
      $display("FAIL illegal_nop instr_cnt got %h want %h", n_instr_cnt, m_cnt + 16'd1);
    end
    n_tests++;
    if (outs !== V_HALT) begin
      n_fail++;
      $display("FAIL illegal_halt outputs got %b want %b", outs, V_HALT);
    end
    @(posedge clk); #1;
    for (int i = 0; i < 99; i++)
      push("halt", 1'($urandom_range(0, 1)), 8'($urandom), V_HALT, 1'b0);
    run_queue("illegal");
  endtask

  task automatic test_async_reset();
    do_reset();
    rst_n = 1'b1;
    push("rst0", 1'b1, 8'hEA, V_IDLE, 1'b0);
    push("rst1", 1'b1, 8'hEA, V_IDLE, 1'b0);
    push_instr(8'hEA);
    push("fetch", 1'b1, 8'h4C, V_FETCH, 1'b0);
    push("dec_abs", 1'b1, 8'h4C, V_DEC_ABS, 1'b0);
    run_queue("async_reset");
    opcode = 8'h4C;
    rdy    = 1'b1;
    #1;
    n_tests++;
    if (outs !== V_ABSH_JMP) begin
      n_fail++;
      $display("FAIL async_pre outputs got %b want %b", outs, V_ABSH_JMP);
    end
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (outs !== V_IDLE) begin
      n_fail++;
      $display("FAIL async_now outputs got %b want %b", outs, V_IDLE);
    end
    n_tests++;
    if (instr_cnt !== 16'd0) begin
      n_fail++;
      $display("FAIL async_now instr_cnt got %h want 0000", instr_cnt);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    m_cnt = 16'd0;
    push("rst0", 1'b1, 8'h4C, V_IDLE, 1'b0);
    push("rst1", 1'b1, 8'h4C, V_IDLE, 1'b0);
    push_instr(8'hA9);
    run_queue("async_reset");
  endtask

  task automatic test_wrap();
    do_reset();
    rst_n = 1'b1;
    force dut.instr_cnt_q = 16'hFFFF;
    #1;
    release dut.instr_cnt_q;
    #1;
    if (instr_cnt === 16'hFFFF) begin
      m_cnt = 16'hFFFF;
      push("rst0", 1'b1, 8'hEA, V_IDLE, 1'b0);
      push("rst1", 1'b1, 8'hEA, V_IDLE, 1'b0);
      push_instr(8'hEA);
      push("fetch_wrapped", 1'b1, 8'hEA, V_FETCH, 1'b0);
      run_queue("wrap");
    end else begin
      $display("[TB] note: counter preload unavailable, wrap scenario skipped");
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_write_no_rdy();
    test_illegal();
    test_async_reset();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

endmodule
